// File: rtl/prbs_gen_chk_if.sv
// Control, data and status bundle between a PRBS generator/checker and its user.
interface prbs_gen_chk_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       mode;
    logic             seed_load;
    logic [30:0]      seed;
    logic             gen_en;
    logic             gen_inj_err;
    logic [W-1:0]     gen_data;
    logic             gen_valid;
    logic             chk_valid;
    logic [W-1:0]     chk_data;
    logic             err_clr;
    logic             chk_locked;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output mode, seed_load, seed, gen_en, gen_inj_err, chk_valid, chk_data, err_clr,
        input  gen_data, gen_valid, chk_locked, err_cnt
    );

    modport slave (
        input  mode, seed_load, seed, gen_en, gen_inj_err, chk_valid, chk_data, err_clr,
        output gen_data, gen_valid, chk_locked, err_cnt
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// Word-parallel PRBS7/15/23/31 generator plus self-synchronising checker with
// lock FSM and saturating bit-error counter.
module prbs_gen_chk #(
    parameter int unsigned W          = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input logic           clk,
    input logic           rst,
    prbs_gen_chk_if.slave bus
);
    localparam int unsigned MW = $clog2(W + 1);
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned AW = ((CNT_W > MW) ? CNT_W : MW) + 1;

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [4:0]       tap_a;
    logic [4:0]       tap_b;
    logic [30:0]      mask;

    logic [1:0]       mode_q;
    logic             mode_chg;

    logic [30:0]      lfsr_q, lfsr_d;
    logic [30:0]      lfsr_step;
    logic [30:0]      seed_m;
    logic [W-1:0]     word_raw;
    logic [W-1:0]     gen_data_q, gen_data_d;
    logic             gen_valid_q, gen_valid_d;

    logic [30:0]      hist_q, hist_d;
    logic [30:0]      hist_step;
    logic [MW-1:0]    mism;
    logic             clean;
    logic [0:0]       state_q, state_d;
    logic [LW-1:0]    lrun_q, lrun_d;
    logic [UW-1:0]    urun_q, urun_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]    err_sum;

    // Tap positions (zero-based) and state mask for the selected polynomial.
    always_comb begin
        tap_a = 5'd30;
        tap_b = 5'd27;
        mask  = 31'h7FFF_FFFF;
        case (bus.mode)
            2'b00: begin tap_a = 5'd6;  tap_b = 5'd5;  mask = 31'h0000_007F; end
            2'b01: begin tap_a = 5'd14; tap_b = 5'd13; mask = 31'h0000_7FFF; end
            2'b10: begin tap_a = 5'd22; tap_b = 5'd17; mask = 31'h007F_FFFF; end
            default: begin tap_a = 5'd30; tap_b = 5'd27; mask = 31'h7FFF_FFFF; end
        endcase
    end

    assign mode_chg = (bus.mode != mode_q);
    assign seed_m   = ((bus.seed & mask) == '0) ? mask : (bus.seed & mask);

    // W serial LFSR steps; the first step lands in the MSB of the word.
    always_comb begin
        lfsr_step = lfsr_q;
        word_raw  = '0;
        for (int i = 0; i < int'(W); i++) begin
            word_raw[W-1-i] = lfsr_step[tap_a] ^ lfsr_step[tap_b];
            lfsr_step       = {lfsr_step[29:0], word_raw[W-1-i]} & mask;
        end
    end

    always_comb begin
        lfsr_d      = lfsr_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        if (mode_chg) begin
            lfsr_d = mask;
        end else if (bus.seed_load) begin
            lfsr_d = seed_m;
        end else if (bus.gen_en) begin
            lfsr_d              = lfsr_step;
            gen_data_d          = word_raw;
            gen_data_d[W-1]     = word_raw[W-1] ^ bus.gen_inj_err;
            gen_valid_d         = 1'b1;
        end
    end

    // Predict each received bit from the history, then shift the received bit in.
    always_comb begin
        hist_step = hist_q;
        mism      = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (bus.chk_data[W-1-i] != (hist_step[tap_a] ^ hist_step[tap_b])) begin
                mism = mism + MW'(1);
            end
            hist_step = {hist_step[29:0], bus.chk_data[W-1-i]};
        end
    end

    assign clean   = (mism == '0) && (hist_q != '0);
    assign err_sum = AW'(err_q) + AW'(mism);

    // Lock FSM, run counters and error accumulation.
    always_comb begin
        state_d = state_q;
        lrun_d  = lrun_q;
        urun_d  = urun_q;
        hist_d  = hist_q;
        err_d   = err_q;
        if (mode_chg) begin
            hist_d  = '0;
            state_d = SEARCH;
            lrun_d  = '0;
            urun_d  = '0;
        end else if (bus.chk_valid) begin
            hist_d = hist_step;
            case (state_q)
                SEARCH: begin
                    if (!clean) begin
                        lrun_d = '0;
                    end else if (lrun_q == LW'(LOCK_CNT - 1)) begin
                        lrun_d  = '0;
                        state_d = LOCKED;
                    end else begin
                        lrun_d = lrun_q + LW'(1);
                    end
                end
                LOCKED: begin
                    err_d = (err_sum > AW'({CNT_W{1'b1}})) ? '1 : err_sum[CNT_W-1:0];
                    if (clean) begin
                        urun_d = '0;
                    end else if (urun_q == UW'(UNLOCK_CNT - 1)) begin
                        urun_d  = '0;
                        state_d = SEARCH;
                    end else begin
                        urun_d = urun_q + UW'(1);
                    end
                end
            endcase
        end
        if (bus.err_clr) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mode_q <= bus.mode;
        if (rst) begin
            lfsr_q      <= mask;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            hist_q      <= '0;
            state_q     <= SEARCH;
            lrun_q      <= '0;
            urun_q      <= '0;
            err_q       <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            hist_q      <= hist_d;
            state_q     <= state_d;
            lrun_q      <= lrun_d;
            urun_q      <= urun_d;
            err_q       <= err_d;
        end
    end

    assign bus.gen_data   = gen_data_q;
    assign bus.gen_valid  = gen_valid_q;
    assign bus.chk_locked = (state_q == LOCKED);
    assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Scoreboard bench for prbs_gen_chk: a bit-queue reference model predicts every
// output cycle, and a negedge monitor compares the DUT against it.
module tb_prbs_gen_chk;
    localparam int unsigned W          = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LOCK_CNT   = 4;
    localparam int unsigned UNLOCK_CNT = 4;
    localparam int          ERR_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             gv;
        logic [W-1:0]     gd;
        logic             lk;
        logic [CNT_W-1:0] ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_gen_chk_if #(.W(W), .CNT_W(CNT_W)) bus ();

    prbs_gen_chk #(
        .W(W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model: generator state and checker history kept as bit queues,
    // element k being the bit produced/received k+1 steps ago.
    bit           gq[$];
    bit           hq[$];
    logic [1:0]   m_prev_mode = 2'b00;
    logic [W-1:0] m_gd = '0;
    bit           m_gv = 1'b0;
    bit           m_locked = 1'b0;
    int           m_run = 0;
    int           m_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void taps(input logic [1:0] m, output int a, output int b, output int n);
        case (m)
            2'b00:   begin a = 7;  b = 6;  n = 7;  end
            2'b01:   begin a = 15; b = 14; n = 15; end
            2'b10:   begin a = 23; b = 18; n = 23; end
            default: begin a = 31; b = 28; n = 31; end
        endcase
    endfunction

    function automatic void load_ones(input int n);
        gq.delete();
        repeat (n) gq.push_back(1'b1);
    endfunction

    function automatic void clear_hist();
        hq.delete();
        repeat (31) hq.push_back(1'b0);
    endfunction

    task automatic model_cycle();
        int a, b, n, mism;
        bit nb, r, nz, any, clean;
        logic [W-1:0] w;
        taps(bus.mode, a, b, n);
        if (rst) begin
            load_ones(n);
            clear_hist();
            m_gd = '0; m_gv = 0; m_locked = 0; m_run = 0; m_err = 0;
        end else if (bus.mode != m_prev_mode) begin
            load_ones(n);
            clear_hist();
            m_gv = 0; m_locked = 0; m_run = 0;
            if (bus.err_clr) m_err = 0;
        end else begin
            if (bus.seed_load) begin
                gq.delete();
                any = 0;
                for (int k = 0; k < n; k++) begin
                    gq.push_back(bus.seed[k]);
                    any |= bus.seed[k];
                end
                if (!any) load_ones(n);
                m_gv = 0;
            end else if (bus.gen_en) begin
                for (int i = 0; i < int'(W); i++) begin
                    nb = gq[a-1] ^ gq[b-1];
                    gq.push_front(nb);
                    void'(gq.pop_back());
                    w[W-1-i] = nb;
                end
                if (bus.gen_inj_err) w[W-1] = ~w[W-1];
                m_gd = w;
                m_gv = 1;
            end else begin
                m_gv = 0;
            end
            if (bus.chk_valid) begin
                nz = 0;
                foreach (hq[k]) if (hq[k]) nz = 1;
                mism = 0;
                for (int i = 0; i < int'(W); i++) begin
                    r = bus.chk_data[W-1-i];
                    if (r != (hq[a-1] ^ hq[b-1])) mism++;
                    hq.push_front(r);
                    void'(hq.pop_back());
                end
                clean = (mism == 0) && nz;
                if (!m_locked) begin
                    m_run = clean ? m_run + 1 : 0;
                    if (m_run == int'(LOCK_CNT)) begin m_locked = 1; m_run = 0; end
                end else begin
                    m_err = (m_err + mism > ERR_MAX) ? ERR_MAX : m_err + mism;
                    m_run = clean ? 0 : m_run + 1;
                    if (m_run == int'(UNLOCK_CNT)) begin m_locked = 0; m_run = 0; end
                end
            end
            if (bus.err_clr) m_err = 0;
        end
        m_prev_mode = bus.mode;
    endtask

    // Predict the post-edge outputs, let the edge pass, then post the expectation.
    task automatic tick();
        exp_t e;
        model_cycle();
        e.gv = m_gv;
        e.gd = m_gd;
        e.lk = m_locked;
        e.ec = CNT_W'(m_err);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.seed_load = 0; bus.seed = '0; bus.gen_en = 0; bus.gen_inj_err = 0;
        bus.chk_valid = 0; bus.chk_data = '0; bus.err_clr = 0;
    endtask

    // One loopback cycle: the word the generator presents now is fed to the checker.
    task automatic lb_cycle(input bit gen, input bit inj, input bit clr);
        bus.seed_load = 0; bus.gen_en = gen; bus.gen_inj_err = inj;
        bus.chk_valid = m_gv; bus.chk_data = m_gd; bus.err_clr = clr;
        tick();
    endtask

    task automatic set_mode(input logic [1:0] m);
        idle_inputs();
        bus.mode = m;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gen_valid",  32'(bus.gen_valid),  32'(e.gv));
            check("gen_data",   32'(bus.gen_data),   32'(e.gd));
            check("chk_locked", 32'(bus.chk_locked), 32'(e.lk));
            check("err_cnt",    32'(bus.err_cnt),    32'(e.ec));
        end
    end

    initial begin
        rst = 1;
        bus.mode = 2'b00;
        idle_inputs();
        repeat (3) tick();
        check("reset_gen_valid", 32'(bus.gen_valid), 32'd0);
        check("reset_gen_data",  32'(bus.gen_data),  32'd0);
        check("reset_locked",    32'(bus.chk_locked), 32'd0);
        check("reset_err_cnt",   32'(bus.err_cnt),   32'd0);
        rst = 0;

        bus.seed_load = 1; bus.seed = 31'h7F;
        tick();
        check("seed_load_no_valid", 32'(bus.gen_valid), 32'd0);
        bus.seed_load = 0; bus.gen_en = 1;
        tick();
        check("prbs7_first_word", 32'(bus.gen_data), 32'h02);
        check("prbs7_first_valid", 32'(bus.gen_valid), 32'd1);
        idle_inputs();
        tick();
        check("hold_gen_data", 32'(bus.gen_data), 32'h02);

        // PRBS31 loopback must lock after exactly eight checked words.
        set_mode(2'b11);
        repeat (9) lb_cycle(1, 0, 0);
        check("prbs31_lock_8_words", 32'(bus.chk_locked), 32'd1);
        repeat (40) lb_cycle($urandom_range(0, 3) != 0, 0, 0);
        check("prbs31_clean_err", 32'(bus.err_cnt), 32'd0);

        // Single injected bit costs three bit errors and keeps lock.
        lb_cycle(1, 1, 0);
        repeat (8) lb_cycle(1, 0, 0);
        check("single_inj_err_cnt", 32'(bus.err_cnt), 32'd3);
        check("single_inj_locked", 32'(bus.chk_locked), 32'd1);

        // Clear wins over the increment of the errored word it coincides with.
        lb_cycle(1, 1, 0);
        lb_cycle(1, 0, 1);
        check("clr_beats_incr", 32'(bus.err_cnt), 32'd0);
        repeat (8) lb_cycle(1, 0, 0);
        lb_cycle(1, 0, 1);

        // Six spaced pulses exceed 15 errors: the counter must saturate.
        repeat (6) begin
            lb_cycle(1, 1, 0);
            repeat (7) lb_cycle(1, 0, 0);
        end
        check("err_saturated", 32'(bus.err_cnt), 32'hF);
        check("sat_still_locked", 32'(bus.chk_locked), 32'd1);
        repeat (6) lb_cycle(1, 1, 0);
        check("unlock_after_errors", 32'(bus.chk_locked), 32'd0);
        check("err_held_sat", 32'(bus.err_cnt), 32'hF);
        repeat (20) lb_cycle(1, 0, 0);
        check("relock_prbs31", 32'(bus.chk_locked), 32'd1);

        // Mode switch drops lock, PRBS15 relocks within eight words.
        set_mode(2'b01);
        check("mode_switch_unlock", 32'(bus.chk_locked), 32'd0);
        check("mode_switch_err_kept", 32'(bus.err_cnt), 32'hF);
        repeat (9) lb_cycle(1, 0, 0);
        check("prbs15_relock", 32'(bus.chk_locked), 32'd1);

        // Randomised traffic over all modes, seeds, injections and clears.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 2) begin
                set_mode(2'($urandom_range(0, 3)));
                continue;
            end
            bus.seed_load   = ($urandom_range(0, 99) < 3);
            bus.seed        = ($urandom_range(0, 3) == 0) ? 31'h0 : 31'($urandom());
            bus.gen_en      = ($urandom_range(0, 9) != 0);
            bus.gen_inj_err = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.chk_valid = 1;
                bus.chk_data  = W'($urandom());
            end else begin
                bus.chk_valid = m_gv;
                bus.chk_data  = m_gd;
            end
            bus.err_clr = ($urandom_range(0, 99) == 0);
            tick();
        end

        // Reset mid-stream with traffic still applied.
        repeat (12) lb_cycle(1, 0, 0);
        rst = 1;
        lb_cycle(1, 1, 0);
        lb_cycle(1, 0, 0);
        check("midrst_gen_valid", 32'(bus.gen_valid), 32'd0);
        check("midrst_gen_data",  32'(bus.gen_data),  32'd0);
        check("midrst_locked",    32'(bus.chk_locked), 32'd0);
        check("midrst_err_cnt",   32'(bus.err_cnt),   32'd0);
        rst = 0;
        idle_inputs();
        tick();
        check("post_rst_no_valid", 32'(bus.gen_valid), 32'd0);
        repeat (12) lb_cycle(1, 0, 0);

        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 Parameter W, default 8: bits per word on gen_data/chk_data; legal range 1..32.
REQ-002 Parameter CNT_W, default 16: error-counter width.
REQ-003 Parameter LOCK_CNT, default 4: consecutive clean words needed to lock.
REQ-004 Parameter UNLOCK_CNT, default 4: consecutive errored words needed to lose lock.
REQ-005 clk  in  1: the single clock; all state changes on its rising edge.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 mode  in  2: polynomial select. 00 = PRBS7 (x^7+x^6+1). 01 = PRBS15 (x^15+x^14+1). 10 = PRBS23 (x^23+x^18+1). 11 = PRBS31 (x^31+x^28+1).
REQ-008 seed_load  in  1: load seed into the generator LFSR.
REQ-009 seed  in  31: seed value; only the low N bits are used, where N is the selected order.
REQ-010 gen_en  in  1: advance the generator by one word.
REQ-011 gen_inj_err  in  1: invert one bit of the word generated this cycle.
REQ-012 gen_data  out  W: generated word.
REQ-013 gen_valid  out  1: gen_data is a new word.
REQ-014 chk_valid  in  1: chk_data holds a word to check.
REQ-015 chk_data  in  W: received word.
REQ-016 err_clr  in  1: clear err_cnt.
REQ-017 chk_locked  out  1: checker is in the LOCKED state.
REQ-018 err_cnt  out  CNT_W: saturating count of errored bits.

Function
REQ-019 Serial step, order N with taps a,b: new = s[a-1]^s[b-1]; s <= {s[N-2:0], new}; the output bit is new. Bits at or above N in the state register SHALL be held at 0.
REQ-020 One word advances the LFSR W serial steps in a single cycle. gen_data[W-1] is the earliest bit in time; gen_data[0] is the latest.
REQ-021 gen_data and gen_valid are registered: a word requested by gen_en at cycle t appears at t+1. When gen_en=0, gen_valid=0 and gen_data holds its last value.
REQ-022 seed_load takes priority over gen_en: the LFSR loads seed, masked to N bits, and no word is emitted that cycle. A masked seed of 0 loads all-ones instead.
REQ-023 gen_inj_err inverts gen_data[W-1] of the emitted word only; LFSR state is unaffected. It is ignored when gen_en=0.
REQ-024 Checker is self-synchronising: it holds a 31-bit history of received bits, processed serially in the same bit order as REQ-020. Each bit r is compared with h[a-1]^h[b-1], then shifted into the history. mism = number of mismatching bits in the word, range 0..W.
REQ-025 A word is clean when mism=0 and the history was nonzero before the word. Otherwise the word is errored.
REQ-026 Checker FSM states: SEARCH (reset state), LOCKED.
- SEARCH: counts consecutive clean words; any errored word resets the count.
- SEARCH -> LOCKED when the count reaches LOCK_CNT.
- LOCKED: counts consecutive errored words; any clean word resets the count.
- LOCKED -> SEARCH when the count reaches UNLOCK_CNT.
REQ-027 In LOCKED, every accepted word adds mism to err_cnt, saturating at 2^CNT_W-1. In SEARCH, err_cnt is not modified.
REQ-028 Checker state and err_cnt update one cycle after the chk_valid cycle. The checker is idle when chk_valid=0.
REQ-029 err_clr sets err_cnt to 0 and wins over a simultaneous increment. It does not affect the FSM.
REQ-030 A change of mode between consecutive cycles does all of the following next cycle: generator LFSR <= all-ones (N bits); checker history <= 0; FSM <= SEARCH; both run counters <= 0. err_cnt is kept.

Reset
REQ-031 While rst=1, the following SHALL hold:
- LFSR = all-ones in the current mode; history = 0.
- gen_data = 0; gen_valid = 0; chk_locked = 0; err_cnt = 0.
- FSM = SEARCH; run counters = 0.
REQ-032 rst overrides every other input. Reset mid-operation discards any in-flight word. gen_valid is 0 the cycle after rst falls unless gen_en is asserted that cycle.

Verification
REQ-033 W=8, mode=00, seed_load with seed=7'h7F, then gen_en for one cycle -> gen_data=8'h02 and gen_valid=1, one cycle later.
REQ-034 mode=11, gen_data looped to chk_data with gen_valid as chk_valid, 1000 words -> chk_locked=1 within 8 words, err_cnt=0 throughout.
REQ-035 Locked PRBS31 loopback, single gen_inj_err pulse -> err_cnt=3, chk_locked stays 1.
REQ-036 Errored word accepted in the same cycle as err_clr -> err_cnt=0 on the next cycle.
REQ-037 CNT_W=4, locked loopback, gen_inj_err held high:
- UNLOCK_CNT applies: after 4 errored words chk_locked=0.
- Before that, err_cnt saturates at 4'hF.
REQ-038 While locked, switch mode 11->01 -> chk_locked=0 next cycle, relock within 8 words. Separately, rst pulsed mid-stream -> all outputs equal their REQ-031 values.
